// File: rtl/grade_pkg.sv
// Shared grade types and limits for the grade entry and 7-seg display stages.
// Clamp helpers keep the limit check in one place.
package grade_pkg;

  localparam int unsigned NBITS_NOTA = 4;
  localparam int unsigned MAX_NOTA   = 10;

  typedef logic [NBITS_NOTA-1:0] nota_t;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    CAPTURE,
    WAIT_REL,
    DB_REL
  } entry_state_t;

  function automatic logic nota_over(input nota_t v);
    return v > nota_t'(MAX_NOTA);
  endfunction

  function automatic nota_t nota_clamp(input nota_t v);
    return nota_over(v) ? nota_t'(MAX_NOTA) : v;
  endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Two-flop synchronisers for the raw button and switches, plus the debounce FSM
// that yields exactly one capture pulse per debounced press.
module debounce_fsm
  import grade_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic [NBITS_NOTA-1:0] sw_nota,
  input  logic                  btn_load,
  output logic [NBITS_NOTA-1:0] sw_s,
  output logic                  capture,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic         btn_meta_q, btn_s_q;
  nota_t        sw_meta_q, sw_s_q;
  entry_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_meta_q <= btn_load;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw_nota;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A level change always wins over a counter that has just reached its limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = DB_PRESS;
          cnt_d   = CntOne;
        end
      end
      DB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      CAPTURE: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
      WAIT_REL: begin
        if (!btn_s_q) begin
          state_d = DB_REL;
          cnt_d   = CntOne;
        end
      end
      DB_REL: begin
        if (btn_s_q) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_s    = sw_s_q;
  assign capture = (state_q == CAPTURE);
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/grade_entry.sv
// Grade entry stage: debounced load button captures the switch grade, clamps it and
// registers it for the display. Define GRADE_AVG_EN to output a rounded 4-capture average.
module grade_entry
  import grade_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic [NBITS_NOTA-1:0] sw_nota,
  input  logic                  btn_load,
  output logic [NBITS_NOTA-1:0] nota,
  output logic                  nota_valid,
  output logic                  nota_stb,
  output logic                  clamped,
  output logic                  busy
);

  nota_t sw_s;
  logic  capture;

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce_fsm (
    .clk_2   (clk_2),
    .rst_n   (rst_n),
    .sw_nota (sw_nota),
    .btn_load(btn_load),
    .sw_s    (sw_s),
    .capture (capture),
    .busy    (busy)
  );

  nota_t cap_val;
  logic  cap_over;
  nota_t new_nota;

  assign cap_over = nota_over(sw_s);
  assign cap_val  = nota_clamp(sw_s);

`ifdef GRADE_AVG_EN
  // Slot 0 holds the newest capture; the first capture after reset primes every slot.
  nota_t [3:0] hist_q, hist_d;
  logic  [5:0] sum4;
  logic  [5:0] rounded;

  always_comb begin
    hist_d = hist_q;
    if (capture) begin
      if (!nota_valid) begin
        hist_d = {4{cap_val}};
      end else begin
        hist_d = {hist_q[2:0], cap_val};
      end
    end
  end

  assign sum4     = 6'(hist_d[0]) + 6'(hist_d[1]) + 6'(hist_d[2]) + 6'(hist_d[3]);
  assign rounded  = sum4 + 6'd2;
  assign new_nota = nota_t'(rounded >> 2);

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign new_nota = cap_val;
`endif

  nota_t nota_q, nota_d;
  logic  valid_q, valid_d;
  logic  clamped_q, clamped_d;
  logic  stb_q;

  always_comb begin
    nota_d    = nota_q;
    valid_d   = valid_q;
    clamped_d = clamped_q;
    if (capture) begin
      nota_d    = new_nota;
      valid_d   = 1'b1;
      clamped_d = cap_over;
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      nota_q    <= '0;
      valid_q   <= 1'b0;
      clamped_q <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      nota_q    <= nota_d;
      valid_q   <= valid_d;
      clamped_q <= clamped_d;
      stb_q     <= capture;
    end
  end

  assign nota       = nota_q;
  assign nota_valid = valid_q;
  assign clamped    = clamped_q;
  assign nota_stb   = stb_q;

endmodule

// File: tb/tb_grade_entry.sv
// Self-checking bench for grade_entry (DEBOUNCE_CYCLES=3): run-length reference model
// compared every cycle, plus hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_grade_entry;
  import grade_pkg::*;

  localparam int DB = 3;
`ifdef GRADE_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic  clk_2 = 1'b0;
  logic  rst_n = 1'b0;
  nota_t sw_nota = '0;
  logic  btn_load = 1'b0;
  nota_t nota;
  logic  nota_valid, nota_stb, clamped, busy;

  int checks = 0;
  int failures = 0;

  grade_entry #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_2     (clk_2),
    .rst_n     (rst_n),
    .sw_nota   (sw_nota),
    .btn_load  (btn_load),
    .nota      (nota),
    .nota_valid(nota_valid),
    .nota_stb  (nota_stb),
    .clamped   (clamped),
    .busy      (busy)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: a press is accepted after DB+1 consecutive high synced samples,
  // the following cycle samples the switches, and re-arming needs DB+1 consecutive lows.
  localparam int MWaitPress = 0, MCapture = 1, MWaitRel = 2;
  int   mode = MWaitPress, press_run = 0, rel_run = 0;
  int   m_btn1 = 0, m_btn_s = 0, m_sw1 = 0, m_sw_s = 0;
  int   m_nota = 0, m_valid = 0, m_stb = 0, m_clamped = 0, m_busy = 0;
  int   hq[$];

  task automatic model_capture(input int v);
    int c, sum;
    c = (v > MAX_NOTA) ? MAX_NOTA : v;
    m_clamped = (v > MAX_NOTA) ? 1 : 0;
    if (AVG) begin
      if (m_valid == 0) begin
        hq = {};
        for (int k = 0; k < 4; k++) hq.push_back(c);
      end else begin
        hq.push_back(c);
        void'(hq.pop_front());
      end
      sum = 0;
      foreach (hq[k]) sum += hq[k];
      m_nota = (sum + 2) / 4;
    end else begin
      m_nota = c;
    end
    m_valid = 1;
    m_stb = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk_2 or negedge rst_n);
      if (!rst_n) begin
        mode = MWaitPress; press_run = 0; rel_run = 0;
        m_btn1 = 0; m_btn_s = 0; m_sw1 = 0; m_sw_s = 0;
        m_nota = 0; m_valid = 0; m_stb = 0; m_clamped = 0; m_busy = 0;
        hq = {};
      end else begin
        m_stb = 0;
        case (mode)
          MWaitPress: begin
            press_run = (m_btn_s != 0) ? press_run + 1 : 0;
            if (press_run == DB + 1) mode = MCapture;
          end
          MCapture: begin
            model_capture(m_sw_s);
            mode = MWaitRel;
            rel_run = 0;
          end
          default: begin
            rel_run = (m_btn_s == 0) ? rel_run + 1 : 0;
            if (rel_run == DB + 1) begin
              mode = MWaitPress;
              press_run = 0;
            end
          end
        endcase
        m_busy = (mode != MWaitPress || press_run > 0) ? 1 : 0;
        m_btn_s = m_btn1; m_btn1 = int'(btn_load);
        m_sw_s = m_sw1;   m_sw1 = int'(sw_nota);
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk_2);
      checks++;
      if (int'(nota) != m_nota || int'(nota_valid) != m_valid || int'(nota_stb) != m_stb ||
          int'(clamped) != m_clamped || int'(busy) != m_busy) begin
        failures++;
        $display("FAIL model t=%0t got nota=%0d valid=%0d stb=%0d clamped=%0d busy=%0d exp %0d %0d %0d %0d %0d",
                 $time, nota, nota_valid, nota_stb, clamped, busy,
                 m_nota, m_valid, m_stb, m_clamped, m_busy);
      end
    end
  end

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, actual, expected);
    end
  endtask

  // Drives pat[i] on btn_load for cycle i; optionally changes sw_nota at cycle chg_at.
  task automatic run_pattern(input logic [63:0] pat, input int n, input int chg_at,
                             input nota_t chg_val, output int lat, output int nstb);
    lat = -1;
    nstb = 0;
    for (int i = 0; i < n; i++) begin
      btn_load = pat[i];
      if (i == chg_at) sw_nota = chg_val;
      @(negedge clk_2);
      if (nota_stb) begin
        nstb++;
        if (lat < 0) lat = i + 1;
      end
      @(posedge clk_2);
      #1;
    end
    btn_load = 1'b0;
  endtask

  int lat, nstb;
  int avg_exp[4];
  int plain_exp[4];
  int seq_in[4];

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk_2);
    #1 rst_n = 1'b1;
    @(negedge clk_2);
    check_int("reset_nota", int'(nota), 0);
    check_int("reset_valid", int'(nota_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    @(posedge clk_2);
    #1;

    // 2 sync edges, DB+1 stable samples, capture cycle, strobe edge: stb seen at DB+5.
    sw_nota = 4'd7;
    run_pattern(64'h3FF, 24, -1, '0, lat, nstb);
    check_int("p7_nstb", nstb, 1);
    check_int("p7_latency", lat, DB + 5);
    check_int("p7_nota", int'(nota), 7);
    check_int("p7_valid", int'(nota_valid), 1);
    check_int("p7_clamped", int'(clamped), 0);
    check_int("p7_busy_end", int'(busy), 0);

    sw_nota = 4'd13;
    run_pattern(64'hFF, 22, -1, '0, lat, nstb);
    check_int("p13_nstb", nstb, 1);
    check_int("p13_nota", int'(nota), AVG ? 8 : 10);
    check_int("p13_clamped", int'(clamped), 1);

    // Switch moves to 12 after the capture; must not affect the grade.
    sw_nota = 4'd5;
    run_pattern(64'hFF, 22, 10, 4'd12, lat, nstb);
    check_int("p5_nstb", nstb, 1);
    check_int("p5_nota", int'(nota), AVG ? 7 : 5);
    check_int("p5_clamped", int'(clamped), 0);

    run_pattern(64'h3, 14, -1, '0, lat, nstb);
    check_int("glitch_nstb", nstb, 0);
    check_int("glitch_nota", int'(nota), AVG ? 7 : 5);
    check_int("glitch_busy", int'(busy), 0);

    // Hold 8 cycles, then release bounce 0-1-0 before settling low.
    sw_nota = 4'd2;
    run_pattern(64'h2FF, 26, -1, '0, lat, nstb);
    check_int("bounce_nstb", nstb, 1);
    check_int("bounce_nota", int'(nota), AVG ? 6 : 2);
    check_int("bounce_busy", int'(busy), 0);

    sw_nota = 4'd9;
    run_pattern(64'hFF, 22, -1, '0, lat, nstb);
    check_int("clean_nstb", nstb, 1);
    check_int("clean_nota", int'(nota), AVG ? 7 : 9);

    // Reset while debouncing a press.
    btn_load = 1'b1;
    repeat (4) begin
      @(posedge clk_2);
      #1;
    end
    check_int("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    btn_load = 1'b0;
    #1;
    check_int("async_nota", int'(nota), 0);
    check_int("async_valid", int'(nota_valid), 0);
    check_int("async_clamped", int'(clamped), 0);
    check_int("async_busy", int'(busy), 0);
    check_int("async_stb", int'(nota_stb), 0);
    @(posedge clk_2);
    #1 rst_n = 1'b1;
    run_pattern(64'h0, 10, -1, '0, lat, nstb);
    check_int("post_reset_nstb", nstb, 0);
    check_int("post_reset_busy", int'(busy), 0);

    seq_in    = '{8, 4, 4, 4};
    avg_exp   = '{8, 7, 6, 5};
    plain_exp = '{8, 4, 4, 4};
    for (int k = 0; k < 4; k++) begin
      sw_nota = nota_t'(seq_in[k]);
      run_pattern(64'hFF, 22, -1, '0, lat, nstb);
      check_int($sformatf("seq%0d_nstb", k), nstb, 1);
      check_int($sformatf("seq%0d_nota", k), int'(nota), AVG ? avg_exp[k] : plain_exp[k]);
    end

    @(negedge clk_2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
